// File: rtl/mem_pkg.sv
// Shared types and access-legality check for the load/store memory stage.
package mem_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {
    BYTE = 2'h0,
    HALF = 2'h1,
    WORD = 2'h2
  } size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mac_state_t;

  // Attributes of the accepted access, needed again when the read data returns.
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       sgn;
    logic [1:0] off;
  } req_t;

  // True when the access must fault without touching the bus.
  function automatic logic mem_bad(input logic [1:0] size, input logic [1:0] off,
                                   input logic we, input logic rd);
    logic illegal, misal;
    illegal = (size == 2'h3) || (we && rd);
    misal   = ((size == HALF) && off[0]) || ((size == WORD) && (off != 2'b00));
    return illegal || misal;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data/enables onto lanes, and lane extraction with extension for loads.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]                        st_size,
  input  logic [1:0]                        st_off,
  input  logic [31:0]                       wdata,
  output logic [NUM_LANES-1:0]              be,
  output logic [31:0]                       lane_wdata,
  input  logic [1:0]                        ld_size,
  input  logic                              ld_sgn,
  input  logic [1:0]                        ld_off,
  input  logic [31:0]                       bus_rdata,
  output logic [31:0]                       rdata_ext
);

  logic [NUM_LANES-1:0][LANE_W-1:0] rlanes;
  logic [7:0]                       rb;
  logic [15:0]                      rh;

  assign rlanes = bus_rdata;

  always_comb begin
    be         = '0;
    lane_wdata = wdata;
    case (st_size)
      BYTE: begin
        be         = 4'b0001 << st_off;
        lane_wdata = {4{wdata[7:0]}};
      end
      HALF: begin
        be         = st_off[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata[15:0]}};
      end
      WORD: be = 4'b1111;
      default: be = '0;
    endcase
  end

  // WORD ignores the signed bit; narrower fields replicate their top bit only when signed.
  always_comb begin
    rb = rlanes[ld_off];
    rh = ld_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (ld_size)
      BYTE:    rdata_ext = {{24{ld_sgn & rb[7]}}, rb};
      HALF:    rdata_ext = {{16{ld_sgn & rh[15]}}, rh};
      default: rdata_ext = bus_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: one req/ack bus transaction at a time, stalls the core until the access completes.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = $clog2(TIMEOUT+1)
)(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic        MemW,
  input  logic        MemRead,
  input  logic [2:0]  memSelect,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  mac_state_t      state, nxt;
  req_t            req_q;
  logic [TO_W-1:0] cnt;
  logic            accept, bad, timeout;
  logic [3:0]      st_be;
  logic [31:0]     st_wdata, ld_data;

  assign accept  = ex_valid & (MemW | MemRead);
  assign bad     = mem_bad(memSelect[1:0], addr[1:0], MemW, MemRead);
  assign timeout = (cnt == TO_W'(TIMEOUT-1));

  mem_lane_align u_align (
    .st_size    (memSelect[1:0]),
    .st_off     (addr[1:0]),
    .wdata      (wdata),
    .be         (st_be),
    .lane_wdata (st_wdata),
    .ld_size    (req_q.size),
    .ld_sgn     (req_q.sgn),
    .ld_off     (req_q.off),
    .bus_rdata  (bus_rdata),
    .rdata_ext  (ld_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = bad ? RESP : ACCESS;
      ACCESS:  if (bus_err || bus_ack || timeout) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Gated by reset_n so the core is released the instant reset hits, even with its inputs still held.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = accept;
      ACCESS:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
    stall = stall & reset_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q       <= '0;
      cnt         <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      fault       <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wdata   <= '0;
    end else begin
      rdata_valid <= 1'b0;
      fault       <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            req_q     <= '{we: MemW, size: memSelect[1:0], sgn: memSelect[2], off: addr[1:0]};
            bus_we    <= MemW;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= st_be;
            bus_wdata <= st_wdata;
            if (bad) fault   <= 1'b1;
            else     bus_req <= 1'b1;
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (bus_err) begin
            fault   <= 1'b1;
            bus_req <= 1'b0;
          end else if (bus_ack) begin
            bus_req <= 1'b0;
            if (!req_q.we) begin
              rdata       <= ld_data;
              rdata_valid <= 1'b1;
            end
          end else if (timeout) begin
            fault   <= 1'b1;
            bus_req <= 1'b0;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized checks of mem_access_unit against an arithmetic lane/extension model.
module tb_mem_access_unit;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        ex_valid = 1'b0, MemW = 1'b0, MemRead = 1'b0;
  logic [2:0]  memSelect = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic        stall, rdata_valid, fault, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0, bus_err = 1'b0;
  logic [31:0] bus_rdata = '0;

  int          errors = 0, checks = 0;
  logic [31:0] model_rdata;
  int          n_stall, n_req, n_rv, n_flt;
  logic        seen_done, unstable, s_we;
  logic [31:0] s_addr, s_wdata, resp_rdata;
  logic [3:0]  s_be;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .MemW(MemW), .MemRead(MemRead),
    .memSelect(memSelect), .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .fault(fault), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] m_be(input int sz, input int off);
    int bytes, base;
    bytes = 1 << sz;
    base  = off - (off % bytes);
    return 4'(((1 << bytes) - 1) << base);
  endfunction

  function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] wd);
    int bytes;
    logic [63:0] v, r;
    bytes = 1 << sz;
    v = {32'd0, wd} & ((64'd1 << (8*bytes)) - 64'd1);
    r = '0;
    for (int k = 0; k < 4/bytes; k++) r = r + (v << (8*bytes*k));
    return r[31:0];
  endfunction

  function automatic logic [31:0] m_load(input int sz, input logic sgn, input int off, input logic [31:0] d);
    int bytes, bits, base;
    logic [63:0] v;
    bytes = 1 << sz;
    bits  = 8 * bytes;
    base  = off - (off % bytes);
    v = {32'd0, d} >> (8*base);
    if (bits < 32) begin
      v = v & ((64'd1 << bits) - 64'd1);
      if (sgn && v >= (64'd1 << (bits-1))) v = v - (64'd1 << bits);
    end
    return v[31:0];
  endfunction

  // Drives one request, plays the bus slave, and tallies what the DUT showed each cycle.
  task automatic run(input logic we, input logic rd, input logic [2:0] sel, input logic [31:0] a,
                     input logic [31:0] wd, input int resp_at, input logic ack, input logic err,
                     input logic [31:0] rdd);
    int cyc, acc;
    @(negedge clk);
    ex_valid = 1'b1; MemW = we; MemRead = rd; memSelect = sel; addr = a; wdata = wd;
    cyc = 0; acc = 0; n_stall = 0; n_req = 0; n_rv = 0; n_flt = 0;
    seen_done = 1'b0; unstable = 1'b0;
    while (!seen_done && cyc < 64) begin
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
      if (bus_req) begin
        if (acc == 0) {s_we, s_addr, s_be, s_wdata} = {bus_we, bus_addr, bus_be, bus_wdata};
        else if ({s_we, s_addr, s_be, s_wdata} !== {bus_we, bus_addr, bus_be, bus_wdata}) unstable = 1'b1;
        if (acc == resp_at) begin bus_ack = ack; bus_err = err; bus_rdata = rdd; end
        n_req++; acc++;
      end
      #1;
      if (stall) n_stall++;
      if (rdata_valid) n_rv++;
      if (fault) n_flt++;
      if (!stall && cyc > 0) begin seen_done = 1'b1; resp_rdata = rdata; end
      cyc++;
      if (!seen_done) @(negedge clk);
    end
    ex_valid = 1'b0; MemW = 1'b0; MemRead = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
    @(negedge clk); #1;
    if (stall) n_stall++;
    if (rdata_valid) n_rv++;
    if (fault) n_flt++;
    if (bus_req) n_req++;
  endtask

  task automatic access(input string tag, input logic we, input logic rd, input logic [2:0] sel,
                        input logic [31:0] a, input logic [31:0] wd, input int resp_at,
                        input logic ack, input logic err, input logic [31:0] rdd);
    int sz, off, e_req, e_stall;
    logic active, bad, responded, e_flt, e_rv;
    sz = int'(sel[1:0]);
    off = int'(a[1:0]);
    active = we | rd;
    bad = (sz == 3) || (we && rd) || ((off % (1 << sz)) != 0);
    if (!active) begin
      e_req = 0; e_stall = 0; e_flt = 1'b0; e_rv = 1'b0;
    end else if (bad) begin
      e_req = 0; e_stall = 1; e_flt = 1'b1; e_rv = 1'b0;
    end else begin
      responded = (resp_at >= 0) && (resp_at < TIMEOUT) && (ack || err);
      e_req   = responded ? resp_at + 1 : TIMEOUT;
      e_stall = e_req + 1;
      e_flt   = !responded || err;
      e_rv    = rd && !e_flt;
    end
    run(we, rd, sel, a, wd, resp_at, ack, err, rdd);
    if (e_rv) model_rdata = m_load(sz, sel[2], off, rdd);
    chk({tag, "_done"}, 32'(seen_done), 32'd1);
    chk({tag, "_stall_cycles"}, n_stall, e_stall);
    chk({tag, "_req_cycles"}, n_req, e_req);
    chk({tag, "_fault_pulses"}, n_flt, 32'(e_flt));
    chk({tag, "_rvalid_pulses"}, n_rv, 32'(e_rv));
    chk({tag, "_rdata"}, resp_rdata, model_rdata);
    if (e_req > 0) begin
      chk({tag, "_bus_we"}, 32'(s_we), 32'(we));
      chk({tag, "_bus_addr"}, s_addr, {a[31:2], 2'b00});
      chk({tag, "_bus_be"}, 32'(s_be), 32'(m_be(sz, off)));
      if (we) chk({tag, "_bus_wdata"}, s_wdata, m_wdata(sz, wd));
      chk({tag, "_bus_stable"}, 32'(unstable), 32'd0);
    end
  endtask

  initial begin
    model_rdata = '0;
    #3;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_outs", {fault, rdata_valid, bus_we, bus_be}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    access("strb", 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0000_00AB, 1, 1'b1, 1'b0, 32'h0);
    chk("strb_be_lit", 32'(s_be), 32'h8);
    chk("strb_wdata_lit", s_wdata, 32'hABAB_ABAB);
    chk("strb_addr_lit", s_addr, 32'h0000_1000);
    chk("strb_stall_lit", n_stall, 3);

    access("ldrsb", 1'b0, 1'b1, 3'b100, 32'h0000_2001, 32'h0, 0, 1'b1, 1'b0, 32'h1234_8056);
    chk("ldrsb_lit", resp_rdata, 32'hFFFF_FF80);
    access("ldrb", 1'b0, 1'b1, 3'b000, 32'h0000_2001, 32'h0, 0, 1'b1, 1'b0, 32'h1234_8056);
    chk("ldrb_lit", resp_rdata, 32'h0000_0080);
    access("ldrsh", 1'b0, 1'b1, 3'b101, 32'h0000_3002, 32'h0, 0, 1'b1, 1'b0, 32'h9ABC_0000);
    chk("ldrsh_be_lit", 32'(s_be), 32'hC);
    chk("ldrsh_lit", resp_rdata, 32'hFFFF_9ABC);
    access("ldrw_sgn", 1'b0, 1'b1, 3'b110, 32'h0000_3000, 32'h0, 2, 1'b1, 1'b0, 32'h9ABC_0000);
    chk("ldrw_lit", resp_rdata, 32'h9ABC_0000);

    access("misal", 1'b0, 1'b1, 3'b010, 32'h0000_4002, 32'h0, 0, 1'b1, 1'b0, 32'h0);
    chk("misal_stall_lit", n_stall, 1);
    access("timeout", 1'b0, 1'b1, 3'b010, 32'h0000_6000, 32'h0, -1, 1'b0, 1'b0, 32'h0);
    chk("timeout_req_lit", n_req, 4);
    access("err_ack", 1'b0, 1'b1, 3'b010, 32'h0000_6004, 32'h0, 0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    chk("err_ack_rdata_lit", resp_rdata, 32'h9ABC_0000);
    access("illegal_sz", 1'b1, 1'b0, 3'b011, 32'h0000_7000, 32'h1, 0, 1'b1, 1'b0, 32'h0);
    access("illegal_rw", 1'b1, 1'b1, 3'b010, 32'h0000_7000, 32'h1, 0, 1'b1, 1'b0, 32'h0);
    access("ignored", 1'b0, 1'b0, 3'b010, 32'h0000_7000, 32'h1, 0, 1'b1, 1'b0, 32'h0);
    access("late_ack", 1'b0, 1'b1, 3'b001, 32'h0000_8002, 32'h0, 3, 1'b1, 1'b0, 32'h7FFF_1234);

    // Reset pulled during the second ACCESS cycle of a held load.
    @(negedge clk);
    ex_valid = 1'b1; MemRead = 1'b1; memSelect = 3'b010; addr = 32'h0000_5000;
    @(negedge clk);
    @(negedge clk); #1;
    chk("rst_mid_pre_req", 32'(bus_req), 32'd1);
    reset_n = 1'b0; #1;
    chk("rst_mid_req", 32'(bus_req), 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_pulses", {fault, rdata_valid}, 32'd0);
    @(negedge clk);
    ex_valid = 1'b0; MemRead = 1'b0; reset_n = 1'b1;
    model_rdata = '0;
    access("post_rst_st", 1'b1, 1'b0, 3'b001, 32'h0000_9002, 32'h0000_C0DE, 0, 1'b1, 1'b0, 32'h0);

    for (int i = 0; i < 40; i++) begin
      logic we, rd;
      int kind;
      kind = int'($urandom_range(0, 9));
      we = (kind < 4) || (kind == 8);
      rd = (kind >= 4);
      if (kind == 9) begin we = 1'b0; rd = 1'b0; end
      access("rnd", we, rd, 3'($urandom_range(0, 7)), $urandom, $urandom,
             int'($urandom_range(0, 5)), 1'($urandom_range(0, 7) != 0),
             1'($urandom_range(0, 5) == 0), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
